// File: rtl/int_controller.sv
// Port-0 interrupt controller: edge-detect, pending latch, mask, fixed-priority
// arbitration, ack/done handshake. Optional REQ timeout under `INT_TIMEOUT_EN.
module int_controller #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 10'h3F0,
    parameter int                    VEC_STRIDE = 2,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_p0,
    input  logic                  mask_we,
    input  logic [7:0]            mask_data,
    input  logic                  gie,
    input  logic                  int_ack,
    input  logic                  int_done,
    output logic                  int_req,
    output logic [ADDR_WIDTH-1:0] int_vector,
    output logic [7:0]            pending,
    output logic                  in_service,
    output logic                  int_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [7:0] s1_q, s2_q, s3_q;
    logic [2:0] prime_q;
    logic [7:0] rise;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q;
    logic [7:0] eligible;
    logic [7:0] clr;
    logic [2:0] idx_q, idx_d;
    logic [2:0] win;
    logic       ack_take;
    logic       to_set;
    logic       tmo_hit;
    logic [ADDR_WIDTH-1:0] vec_off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            prime_q <= '0;
        end else begin
            s1_q    <= in_p0;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    // Edges are suppressed until s3 holds a real pin sample, so lines
    // already high when reset releases do not look like fresh rises.
    assign rise = s2_q & ~s3_q & {8{prime_q[2]}};

    assign eligible = pend_q & mask_q;

    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) win = i[2:0];
        end
    end

    assign clr    = ack_take ? (8'h01 << idx_q) : 8'h00;
    assign pend_d = (pend_q & ~clr) | rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
        end else begin
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            if (mask_we) mask_q <= mask_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        int_req    = 1'b0;
        in_service = 1'b0;
        ack_take   = 1'b0;
        to_set     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gie && (eligible != 8'h00)) begin
                    idx_d   = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                int_req = 1'b1;
                if (int_ack) begin
                    ack_take = 1'b1;
                    state_d  = SERVICE;
                end else if (tmo_hit) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                in_service = 1'b1;
                if (int_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef INT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          tflag_q;

    // Counter is zero on the first REQ cycle, so REQ lasts TIMEOUT cycles.
    assign tcnt_d  = (state_q == REQ) ? tcnt_q + 1'b1 : '0;
    assign tmo_hit = (tcnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_q | to_set;
        end
    end

    assign int_timeout = tflag_q;
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign int_timeout = 1'b0;
    assign unused_cfg  = ^TIMEOUT ^ to_set;
`endif

    assign vec_off    = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(VEC_STRIDE);
    assign int_vector = VEC_BASE + vec_off;
    assign pending    = pend_q;

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: expected lines queued at stimulus,
// popped and checked as each request is served.
module tb_int_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_p0;
    logic       mask_we;
    logic [7:0] mask_data;
    logic       gie;
    logic       int_ack;
    logic       int_done;
    logic       int_req;
    logic [9:0] int_vector;
    logic [7:0] pending;
    logic       in_service;
    logic       int_timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int sb[$];

    int_controller dut (
        .clk        (clk),
        .reset      (reset),
        .in_p0      (in_p0),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .gie        (gie),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .int_req    (int_req),
        .int_vector (int_vector),
        .pending    (pending),
        .in_service (in_service),
        .int_timeout(int_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] vexp(input int line);
        logic [31:0] v;
        v = 32'h3F0 + line * 2;
        return v[9:0];
    endfunction

    task automatic write_mask(input logic [7:0] m);
        mask_we   = 1'b1;
        mask_data = m;
        tick();
        mask_we   = 1'b0;
    endtask

    task automatic serve();
        int n;
        int line;
        n = 0;
        while (!int_req && n < 30) begin
            tick();
            n++;
        end
        chk("req_seen", int_req, 1);
        if (!int_req) return;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        line = sb.pop_front();
        chk("vector", int_vector, vexp(line));
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("in_service", in_service, 1);
        chk("req_low", int_req, 0);
        chk("pend_clr", pending[line], 0);
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
        chk("idle_after_done", in_service, 0);
        chk("dead_cycle", int_req, 0);
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        in_p0     = 8'hFF;
        mask_we   = 1'b0;
        mask_data = 8'h00;
        gie       = 1'b0;
        int_ack   = 1'b0;
        int_done  = 1'b0;
        repeat (2) tick();
        chk("rst_req", int_req, 0);
        chk("rst_vec", int_vector, 10'h3F0);
        chk("rst_pend", pending, 0);
        chk("rst_insvc", in_service, 0);
        chk("rst_tmo", int_timeout, 0);

        reset = 1'b1;
        gie   = 1'b1;
        write_mask(8'hFF);
        repeat (6) tick();
        chk("held_high_pend", pending, 0);
        chk("held_high_req", int_req, 0);
        in_p0 = 8'h00;
        repeat (4) tick();

        // single line, exact latency
        in_p0 = 8'h04;
        sb.push_back(2);
        tick();
        chk("lat_k", pending, 0);
        tick();
        chk("lat_k1", pending, 0);
        tick();
        chk("lat_k2_pend", pending, 8'h04);
        chk("lat_k2_req", int_req, 0);
        tick();
        chk("lat_k3_req", int_req, 1);
        chk("lat_k3_vec", int_vector, 10'h3F4);
        serve();

        // simultaneous lines, priority order
        in_p0 = 8'h00;
        repeat (4) tick();
        in_p0 = 8'h81;
        sb.push_back(0);
        sb.push_back(7);
        serve();
        serve();

        // masked line pends but does not request
        in_p0 = 8'h00;
        repeat (4) tick();
        write_mask(8'hFE);
        in_p0 = 8'h01;
        repeat (6) tick();
        chk("masked_pend", pending, 8'h01);
        chk("masked_req", int_req, 0);
        write_mask(8'hFF);
        chk("unmask_w1", int_req, 0);
        tick();
        chk("unmask_w2", int_req, 1);
        sb.push_back(0);
        serve();
        repeat (6) tick();
        chk("no_repend", pending, 0);
        chk("no_rereq", int_req, 0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_idle_ignored", in_service, 0);

        // request held through gie/mask drop, then async reset
        in_p0 = 8'h00;
        repeat (3) tick();
        in_p0 = 8'h02;
        n = 0;
        while (!int_req && n < 30) begin
            tick();
            n++;
        end
        chk("req2_seen", int_req, 1);
        gie = 1'b0;
        write_mask(8'h00);
        chk("req_held", int_req, 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_req", int_req, 0);
        chk("arst_pend", pending, 0);
        chk("arst_insvc", in_service, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_req", int_req, 0);
        gie = 1'b1;
        write_mask(8'hFF);
        repeat (6) tick();
        chk("post_rst_pend", pending, 0);
        chk("post_rst_idle", int_req, 0);

`ifdef INT_TIMEOUT_EN
        in_p0 = 8'h00;
        repeat (4) tick();
        in_p0 = 8'h08;
        sb.push_back(3);
        n = 0;
        while (!int_req && n < 30) begin
            tick();
            n++;
        end
        chk("tmo_req_seen", int_req, 1);
        n = 0;
        while (int_req && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_len", n, 16);
        chk("tmo_flag", int_timeout, 1);
        chk("tmo_pend", pending[3], 1);
        tick();
        chk("tmo_rearb", int_req, 1);
        serve();
        chk("tmo_sticky", int_timeout, 1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller for the dedicated interrupt port (port 0). It sits alongside the input port bank and watches the same raw in_p0 pin lines.
- Synchronises the 8 lines and detects rising edges, then latches pending requests.
- Applies a CPU-written mask and picks the highest-priority line.
- Drives an interrupt request plus a vector address to the CPU control unit, with an ack/done handshake.

Parameters:
- ADDR_WIDTH, 10, width of the program-memory address carried on int_vector.
- VEC_BASE, 10'h3F0, vector address of line 0.
- VEC_STRIDE, 2, address distance between consecutive line vectors.
- TIMEOUT, 16, cycles int_req may stay unacknowledged (optional feature only).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_p0  input  8  raw interrupt lines (port 0 pins), asynchronous to clk.
- mask_we  input  1  write strobe for the mask register.
- mask_data  input  8  new mask value; 1 enables the line.
- gie  input  1  global interrupt enable from CPU.
- int_ack  input  1  CPU accepted the request (vector fetched).
- int_done  input  1  CPU finished the handler (return-from-interrupt).
- int_req  output  1  interrupt request to CPU.
- int_vector  output  ADDR_WIDTH  handler address, valid while int_req=1.
- pending  output  8  pending-request register.
- in_service  output  1  handler currently executing.
- int_timeout  output  1  sticky timeout flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, pending and idx are cleared to 0; mask is cleared to 8'h00.
  - State goes to IDLE.
  - int_req=0, int_vector=VEC_BASE, in_service=0, int_timeout=0.
- Synchroniser:
  - Two-flop chain s1->s2, plus history flop s3.
  - edge[i] = s2[i] & ~s3[i].
  - Latency: a line first sampled high at clock edge k sets pending[i] at edge k+2.
- Pending update each cycle: pending <= (pending & ~clr) | edge.
  - clr is the one-hot of idx on the cycle int_ack is accepted.
  - A set and a clear of the same bit in one cycle: set wins.
- Mask:
  - On mask_we, mask <= mask_data at the next edge.
  - Masked lines still latch into pending; they are only excluded from arbitration.
- Arbitration: eligible = pending & mask. Priority is fixed: bit 0 highest, bit 7 lowest.
- FSM:
  - IDLE:
    - If gie=1 and eligible!=0: idx <= lowest set bit of eligible, go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - int_req=1.
    - int_vector = VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
    - On int_ack=1: clear pending[idx], go to SERVICE.
    - The request is never withdrawn by a gie drop or a mask change while in REQ; it stays held until ack.
  - SERVICE:
    - int_req=0, in_service=1.
    - On int_done=1: go to IDLE.
    - No nesting; new edges only accumulate in pending.
- IDLE->REQ latency: int_req rises 1 cycle after eligible becomes non-zero, i.e. at edge k+3 from the first pin sample.
- Simultaneous events:
  - int_ack while in IDLE or SERVICE is ignored.
  - int_done while in IDLE or REQ is ignored.
  - int_done and a new eligible line in the same cycle: the FSM goes to IDLE, then REQ on the next cycle (one dead cycle is guaranteed).
- Back-to-back: several pending lines are serviced one per REQ/SERVICE round, in priority order re-evaluated in each IDLE.
- A line held high generates only one edge; it must fall and rise again to re-pend.

Optional Feature:
- Macro: INT_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ and clears when REQ is entered.
  - If it reaches TIMEOUT without int_ack, the FSM returns to IDLE with pending[idx] left set, and int_timeout is set.
  - int_timeout is sticky until reset.
  - Arbitration then restarts normally.
- Undefined: no counter is built, int_timeout is tied to 0, and REQ waits indefinitely.

Test Plan:
- Reset with in_p0=8'hFF held high, then mask=8'hFF, gie=1 -> no edge is detected, pending=8'h00, int_req stays 0.
- in_p0 0->8'h04, mask=8'hFF, gie=1 -> pending=8'h04 at edge k+2, int_req=1 at k+3, int_vector=10'h3F4; int_ack -> pending=8'h00, in_service=1; int_done -> IDLE.
- in_p0 rises 8'h00->8'h81 in one cycle -> line 0 is serviced first (vector 10'h3F0), then line 7 (vector 10'h3FE) after int_done plus one IDLE cycle.
- mask=8'hFE, line 0 edge -> pending=8'h01, no int_req; then write mask=8'hFF -> int_req 2 cycles after the write.
- During REQ drop gie and pulse reset low asynchronously mid-cycle -> int_req, pending and in_service go to 0 immediately, and the FSM is in IDLE after release.
- INT_TIMEOUT_EN, TIMEOUT=16, no int_ack -> int_req falls after 16 cycles, int_timeout=1, pending bit still set, and the request is re-issued once IDLE re-arbitrates.
